// File: rtl/lsu_ctrl_if.sv
// Execute -> LSU -> data memory -> writeback signal bundle.
// slave is the LSU side; master is the surrounding pipeline and memory.
interface lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic [1:0]  mem_width;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic        mem_re;
  logic        mem_signext;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_err;
  logic [1:0]  resp_cause;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    output req_ready,
    output mem_width, mem_addr, mem_we, mem_re, mem_signext, mem_wdata,
    input  mem_rdata,
    output resp_valid, resp_data, resp_rd, resp_err, resp_cause,
    input  resp_ready
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    input  req_ready,
    input  mem_width, mem_addr, mem_we, mem_re, mem_signext, mem_wdata,
    output mem_rdata,
    input  resp_valid, resp_data, resp_rd, resp_err, resp_cause,
    output resp_ready
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store control: decode + legality checks, one-cycle
// memory strobe, then a held response until writeback takes it.
module lsu_ctrl #(
  parameter int unsigned MEM_BYTES = 4020
) (
  input  logic      CLK,
  input  logic      RST_N,
  lsu_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  width;
    logic        signext;
    logic [31:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        err;
    logic [1:0]  cause;
  } resp_t;

  localparam logic [32:0] LAST_BYTE = 33'(MEM_BYTES - 1);

  localparam logic [1:0] W_WORD = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_BYTE = 2'b10;

  localparam logic [1:0] C_NONE  = 2'b00;
  localparam logic [1:0] C_MISAL = 2'b01;
  localparam logic [1:0] C_RANGE = 2'b10;
  localparam logic [1:0] C_ILL   = 2'b11;

  state_e   state_q, state_d;
  mem_req_t mreq_q, mreq_d;
  resp_t    resp_q, resp_d;
  logic     we_q, we_d;

  logic [1:0]  dec_width;
  logic        dec_sext;
  logic        dec_illegal;
  logic [2:0]  dec_size;
  logic [32:0] last_addr;
  logic        misal;
  logic        oor;
  logic [1:0]  cause;
  logic        accept;

  // funct3 decode; the unsigned load encodings are illegal for stores
  always_comb begin
    dec_width   = W_WORD;
    dec_sext    = 1'b0;
    dec_illegal = 1'b0;
    case (bus.req_funct3)
      3'b000: begin dec_width = W_BYTE; dec_sext = ~bus.req_we; end
      3'b001: begin dec_width = W_HALF; dec_sext = ~bus.req_we; end
      3'b010: dec_width = W_WORD;
      3'b100: begin dec_width = W_BYTE; dec_illegal = bus.req_we; end
      3'b101: begin dec_width = W_HALF; dec_illegal = bus.req_we; end
      default: dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (dec_width)
      W_BYTE:  dec_size = 3'd1;
      W_HALF:  dec_size = 3'd2;
      default: dec_size = 3'd4;
    endcase
  end

  // 33-bit last-byte address so accesses near 0xFFFFFFFF cannot wrap
  assign last_addr = {1'b0, bus.req_addr} + {30'd0, dec_size} - 33'd1;
  assign oor       = last_addr > LAST_BYTE;
  assign misal     = ((dec_width == W_HALF) && bus.req_addr[0]) ||
                     ((dec_width == W_WORD) && (bus.req_addr[1:0] != 2'b00));

  always_comb begin
    if (dec_illegal)  cause = C_ILL;
    else if (misal)   cause = C_MISAL;
    else if (oor)     cause = C_RANGE;
    else              cause = C_NONE;
  end

  assign accept = (state_q == IDLE) && bus.req_valid;

  // state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = (cause != C_NONE) ? RESP : ISSUE;
      ISSUE:   state_d = we_q ? RESP : WAIT;
      WAIT:    state_d = RESP;
      RESP:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_re     = 1'b0;
    bus.resp_valid = 1'b0;
    case (state_q)
      IDLE:    bus.req_ready  = 1'b1;
      ISSUE:   begin bus.mem_we = we_q; bus.mem_re = ~we_q; end
      RESP:    bus.resp_valid = 1'b1;
      default: ;
    endcase
  end

  // request latch and response capture
  always_comb begin
    mreq_d = mreq_q;
    resp_d = resp_q;
    we_d   = we_q;
    if (accept) begin
      we_d         = bus.req_we;
      resp_d.data  = '0;
      resp_d.rd    = bus.req_we ? 5'd0 : bus.req_rd;
      resp_d.err   = (cause != C_NONE);
      resp_d.cause = cause;
      // rejected requests leave the memory-side outputs untouched
      if (cause == C_NONE) begin
        mreq_d.addr    = bus.req_addr;
        mreq_d.width   = dec_width;
        mreq_d.signext = dec_sext;
        mreq_d.wdata   = bus.req_wdata;
      end
    end
    if (state_q == WAIT) resp_d.data = bus.mem_rdata;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mreq_q <= '0;
      resp_q <= '0;
      we_q   <= 1'b0;
    end else begin
      mreq_q <= mreq_d;
      resp_q <= resp_d;
      we_q   <= we_d;
    end
  end

  assign bus.mem_addr    = mreq_q.addr;
  assign bus.mem_width   = mreq_q.width;
  assign bus.mem_signext = mreq_q.signext;
  assign bus.mem_wdata   = mreq_q.wdata;

  assign bus.resp_data   = resp_q.data;
  assign bus.resp_rd     = resp_q.rd;
  assign bus.resp_err    = resp_q.err;
  assign bus.resp_cause  = resp_q.cause;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: a byte-array reference model predicts every
// response and memory access; monitors compare whatever the DUT presents.
module tb_lsu_ctrl;
  localparam int MB = 4020;

  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  always #5 CLK = ~CLK;

  lsu_ctrl_if bus();
  lsu_ctrl #(.MEM_BYTES(MB)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        err;
    logic [1:0]  cause;
    int          lat;
    int          acc_cyc;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  width;
    logic        sx;
    logic [31:0] wdata;
  } acc_t;

  exp_t exp_q[$];
  acc_t acc_q[$];

  bit [7:0] mem     [MB];   // memory the DUT talks to
  bit [7:0] ref_mem [MB];   // reference model's view of memory

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int stall_cnt = 0;
  bit rnd_rr = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  function automatic int nbytes(logic [1:0] w);
    return (w == 2'b10) ? 1 : (w == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] mem_read(logic [31:0] a, logic [1:0] w, logic sx);
    logic [31:0] v = '0;
    int n = nbytes(w);
    for (int i = 0; i < n; i++)
      if (64'(a) + 64'(i) < 64'(MB)) v[8*i +: 8] = mem[a + 32'(i)];
    if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  // Memory: writes at the strobe edge, registered read data the cycle after mem_re
  always @(posedge CLK) begin
    if (bus.mem_we)
      for (int i = 0; i < 4; i++)
        if (i < nbytes(bus.mem_width) && 64'(bus.mem_addr) + 64'(i) < 64'(MB))
          mem[bus.mem_addr + 32'(i)] <= bus.mem_wdata[8*i +: 8];
    if (bus.mem_re) bus.mem_rdata <= mem_read(bus.mem_addr, bus.mem_width, bus.mem_signext);
  end

  // Reference model: RV32I load/store semantics over a plain byte array
  task automatic model(bit we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                       logic [4:0] rd, int acc_cyc);
    int sz = 4;
    bit sx = 1'b0;
    bit legal = 1'b1;
    exp_t e;
    acc_t x;
    logic [31:0] v;
    case (f3)
      3'd0: begin sz = 1; sx = !we; end
      3'd1: begin sz = 2; sx = !we; end
      3'd2: sz = 4;
      3'd4: begin sz = 1; legal = !we; end
      3'd5: begin sz = 2; legal = !we; end
      default: legal = 1'b0;
    endcase
    e.rd = we ? 5'd0 : rd;
    e.data = '0;
    e.err = 1'b1;
    e.lat = 0;
    e.acc_cyc = acc_cyc;
    if (!legal) e.cause = 2'b11;
    else if ((a % 32'(sz)) != 0) e.cause = 2'b01;
    else if ({32'd0, a} + 64'(sz) > 64'(MB)) e.cause = 2'b10;
    else begin
      e.err = 1'b0;
      e.cause = 2'b00;
      x.we = we; x.addr = a; x.sx = sx; x.wdata = wd;
      x.width = (sz == 1) ? 2'b10 : (sz == 2) ? 2'b01 : 2'b00;
      acc_q.push_back(x);
      if (we) begin
        for (int i = 0; i < sz; i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
        e.lat = 1;
      end else begin
        v = '0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[a + 32'(i)];
        if (sx && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
        e.data = v;
        e.lat = 2;
      end
    end
    exp_q.push_back(e);
  endtask

  // Driver: presents a request and holds it until the accept edge
  task automatic issue(bit we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd, logic [4:0] rd);
    bit rdy;
    int c;
    int n = 0;
    @(negedge CLK);
    bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = a;
    bus.req_wdata = wd; bus.req_rd = rd; bus.req_valid = 1'b1;
    forever begin
      rdy = bus.req_ready;
      c = cyc;
      @(posedge CLK);
      if (rdy) break;
      n++;
      if (n > 100) begin
        fail("accept_timeout");
        bus.req_valid = 1'b0;
        return;
      end
      @(negedge CLK);
    end
    model(we, f3, a, wd, rd, c + 1);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    chk({tag, "_ctrl"}, 64'({bus.mem_we, bus.mem_re, bus.resp_valid, bus.resp_err,
                            bus.resp_cause, bus.mem_width, bus.mem_signext}), 64'd0);
    chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
    chk({tag, "_resp"}, 64'({bus.resp_data, bus.resp_rd}), 64'd0);
  endtask

  // resp_ready driver: optional forced stall, otherwise always-ready or random
  initial begin
    bus.resp_ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      if (bus.resp_valid && stall_cnt > 0) begin
        bus.resp_ready = 1'b0;
        stall_cnt--;
      end else begin
        bus.resp_ready = rnd_rr ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
  end

  // Monitor: memory strobes and responses against the scoreboard queues
  initial begin
    bit prev_v = 1'b0;
    bit last_hs = 1'b0;
    exp_t e;
    acc_t x;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        prev_v = 1'b0;
        last_hs = 1'b0;
        continue;
      end
      if (bus.mem_we || bus.mem_re) begin
        chk("strobe_exclusive", 64'(bus.mem_we & bus.mem_re), 64'd0);
        if (acc_q.size() == 0) fail("unexpected_strobe");
        else begin
          x = acc_q.pop_front();
          chk("acc_we", 64'(bus.mem_we), 64'(x.we));
          chk("acc_addr", 64'(bus.mem_addr), 64'(x.addr));
          chk("acc_width", 64'(bus.mem_width), 64'(x.width));
          chk("acc_signext", 64'(bus.mem_signext), 64'(x.sx));
          if (x.we) chk("acc_wdata", 64'(bus.mem_wdata), 64'(x.wdata));
        end
      end
      if (prev_v && !bus.resp_valid && !last_hs) fail("resp_valid_dropped");
      last_hs = 1'b0;
      if (bus.resp_valid) begin
        if (exp_q.size() == 0) fail("unexpected_resp");
        else begin
          e = exp_q[0];
          if (!prev_v) chk("latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
          chk("resp_data", 64'(bus.resp_data), 64'(e.data));
          chk("resp_rd", 64'(bus.resp_rd), 64'(e.rd));
          chk("resp_err", 64'(bus.resp_err), 64'(e.err));
          chk("resp_cause", 64'(bus.resp_cause), 64'(e.cause));
          chk("busy_req_ready", 64'(bus.req_ready), 64'd0);
          if (bus.resp_ready) begin
            void'(exp_q.pop_front());
            last_hs = 1'b1;
          end
        end
      end
      prev_v = bus.resp_valid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit we;
    logic [2:0] f3;
    logic [31:0] a;
    int sz;
    int r;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_rd = '0;

    #2 RST_N = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;

    // Directed: word store then loads of every width/sign
    issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 5'd3);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 5'd5);
    issue(1'b0, 3'b000, 32'h13, 32'h0, 5'd6);
    issue(1'b0, 3'b100, 32'h13, 32'h0, 5'd7);
    issue(1'b0, 3'b001, 32'h12, 32'h0, 5'd8);
    // Rejections: misaligned, out of range, illegal funct3
    issue(1'b0, 3'b010, 32'h12, 32'h0, 5'd9);
    issue(1'b1, 3'b001, 32'h11, 32'h1234_5678, 5'd1);
    issue(1'b0, 3'b010, 32'd4020, 32'h0, 5'd10);
    issue(1'b0, 3'b000, 32'hFFFF_FFFF, 32'h0, 5'd11);
    issue(1'b1, 3'b010, 32'd4016, 32'hA5A5_5A5A, 5'd2);
    issue(1'b0, 3'b011, 32'h13, 32'h0, 5'd12);
    issue(1'b1, 3'b100, 32'h20, 32'h0, 5'd13);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 5'd14);
    issue(1'b0, 3'b010, 32'd4016, 32'h0, 5'd15);

    // Held response: writeback stalls 5 cycles while a second request waits
    stall_cnt = 5;
    issue(1'b0, 3'b010, 32'h10, 32'h0, 5'd16);
    issue(1'b0, 3'b100, 32'h13, 32'h0, 5'd17);

    // Reset while the load sits in WAIT: response aborted
    issue(1'b0, 3'b010, 32'h10, 32'h0, 5'd18);
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1 check_reset_outputs("midrst");
    exp_q.delete();
    @(negedge CLK);
    RST_N = 1'b1;
    #1 chk("post_rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("post_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 5'd19);

    // Randomized traffic with random writeback back-pressure
    rnd_rr = 1'b1;
    for (int n = 0; n < 300; n++) begin
      we = 1'(($urandom_range(0, 2) == 0));
      case ($urandom_range(0, 9))
        0, 1:    f3 = 3'b000;
        2, 3:    f3 = 3'b001;
        4, 5, 6: f3 = 3'b010;
        7:       f3 = 3'b100;
        8:       f3 = 3'b101;
        default: f3 = 3'($urandom_range(3, 7));
      endcase
      sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      r = $urandom_range(0, 9);
      if (r < 7)       a = 32'($urandom_range(0, MB - 1));
      else if (r == 7) a = 32'(MB - 12 + $urandom_range(0, 15));
      else if (r == 8) a = $urandom;
      else             a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(sz) - 32'd1);
      issue(we, f3, a, $urandom, 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge CLK);
    end

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge CLK);
    chk("resp_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("acc_queue_drained", 64'(acc_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
